// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared pipeline defaults and stage index constants
package proc_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_AW     = 3;
    localparam int DEF_LOAD_READY = 1;

    localparam int STG_EX  = 0;
    localparam int STG_MEM = 1;
    localparam int STG_WB  = 2;

endpackage

// File: rtl/fwd_port.sv
// rtl/fwd_port.sv - per read port priority match over tracked stages
module fwd_port
    import proc_pkg::*;
#(
    parameter int NSTAGE     = 3,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int LOAD_READY = DEF_LOAD_READY
) (
    input  logic                       req,
    input  logic [REG_AW-1:0]          sel,
    input  logic [NSTAGE-1:0]          v,
    input  logic [NSTAGE-1:0]          ld,
    input  logic [NSTAGE*REG_AW-1:0]   dest,
    input  logic [NSTAGE*DATA_W-1:0]   stage_data,
    output logic                       hit,
    output logic [DATA_W-1:0]          data,
    output logic                       hazard
);

    logic found;

    // Youngest stage (lowest index) that matches decides; a load not yet
    // producing its result turns the match into a hazard instead of a hit.
    always_comb begin
        hit    = 1'b0;
        data   = '0;
        hazard = 1'b0;
        found  = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (!found && req && v[k] && (dest[k*REG_AW +: REG_AW] == sel)) begin
                found = 1'b1;
                if (ld[k] && (k < LOAD_READY)) begin
                    hazard = 1'b1;
                end else begin
                    hit  = 1'b1;
                    data = stage_data[k*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - in-flight destination tracker with forwarding and load-use stall
module fwd_scoreboard
    import proc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int NSTAGE     = 3,
    parameter int NREAD      = 2,
    parameter int LOAD_READY = DEF_LOAD_READY,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic                       issue_wr,
    input  logic                       issue_load,
    input  logic [REG_AW-1:0]          issue_dest,
    input  logic [NREAD-1:0]           rd_req,
    input  logic [NREAD*REG_AW-1:0]    rd_sel,
    input  logic [NSTAGE*DATA_W-1:0]   stage_data,
    input  logic                       flush,
    input  logic                       freeze,
    output logic [NREAD-1:0]           fwd_hit,
    output logic [NREAD*DATA_W-1:0]    fwd_data,
    output logic                       stall,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic [NSTAGE-1:0]        v_q;
    logic [NSTAGE-1:0]        ld_q;
    logic [NSTAGE*REG_AW-1:0] dest_q;
    logic [NREAD-1:0]         port_hazard;
    logic                     new_valid;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        fwd_port #(
            .NSTAGE     (NSTAGE),
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .LOAD_READY (LOAD_READY)
        ) u_port (
            .req        (rd_req[p]),
            .sel        (rd_sel[p*REG_AW +: REG_AW]),
            .v          (v_q),
            .ld         (ld_q),
            .dest       (dest_q),
            .stage_data (stage_data),
            .hit        (fwd_hit[p]),
            .data       (fwd_data[p*DATA_W +: DATA_W]),
            .hazard     (port_hazard[p])
        );
    end

    // A flushed decode instruction never stalls; a stalled or flushed one enters as a bubble.
    always_comb begin
        stall     = issue_valid & ~flush & (|port_hazard);
        new_valid = issue_valid & issue_wr & ~stall & ~flush;
    end

    // Entry pipeline: clear on reset, hold on freeze, otherwise shift toward writeback.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            ld_q   <= '0;
            dest_q <= '0;
        end else if (!freeze) begin
            for (int k = 1; k < NSTAGE; k++) begin
                v_q[k]                   <= v_q[k-1];
                ld_q[k]                  <= ld_q[k-1];
                dest_q[k*REG_AW +: REG_AW] <= dest_q[(k-1)*REG_AW +: REG_AW];
            end
            v_q[STG_EX]                       <= new_valid;
            ld_q[STG_EX]                      <= new_valid & issue_load;
            dest_q[STG_EX*REG_AW +: REG_AW]   <= issue_dest;
        end
    end

    // Saturating count of cycles the pipeline actually spent stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !freeze && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard scoreboard for the pipelined core; it generalises the fixed 3-stage, 2-operand forwarding vector into a stateful tracker.
- Sits beside decode and records, per post-decode stage, each in-flight destination register and whether the instruction is a load.
- Drives per-read-port forwarding selects and data, plus a load-use stall.
- Squashes entries on branch flush, holds all state on a global freeze, and counts stall cycles.

## Interface
- DATA_W, 16, register/data width
- REG_AW, 3, register address width (2**REG_AW architectural registers, none hardwired)
- NSTAGE, 3, tracked stages; index 0 = execute, 1 = memory, 2 = writeback
- NREAD, 2, decode read ports
- LOAD_READY, 1, lowest stage index at which a load's result appears on stage_data
- CNT_W, 16, stall counter width

Ports (reset is synchronous, active-high, on `rst`; everything is clocked on `clk`):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode holds a valid instruction this cycle
- issue_wr  in  1  instruction writes a register
- issue_load  in  1  instruction is a load
- issue_dest  in  REG_AW  destination register
- rd_req  in  NREAD  port p reads a register
- rd_sel  in  NREAD*REG_AW  source register per port, port p at [p*REG_AW +: REG_AW]
- stage_data  in  NSTAGE*DATA_W  result currently produced in stage k, at [k*DATA_W +: DATA_W]
- flush  in  1  branch/jump taken in execute; squash the decode instruction
- freeze  in  1  global hold (memory busy, halt)
- fwd_hit  out  NREAD  port p must use fwd_data instead of register file
- fwd_data  out  NREAD*DATA_W  forwarded value per port
- stall  out  1  load-use hazard; decode and fetch must hold
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
- State per stage k: v[k], dest[k], ld[k]. Reset clears all v, ld, and stall_cnt.
- Match for port p at stage k: rd_req[p] & v[k] & dest[k]==rd_sel[p].
- The youngest match (lowest k) wins; older matches are ignored.
- On a winning match at stage k with ld[k] and k < LOAD_READY, the port is not ready: port hazard = 1 and fwd_hit[p] = 0.
- On any other winning match: fwd_hit[p] = 1 and fwd_data[p] = stage_data[k].
- With no match: fwd_hit[p] = 0 and fwd_data[p] = 0.
- stall = issue_valid & ~flush & OR(port hazards).
- Next state, highest priority first:
  1. rst: clear.
  2. freeze: hold every entry.
  3. Otherwise shift: entry k+1 takes entry k; the oldest entry drops.
- The new entry 0 is valid only when issue_valid & issue_wr & ~stall & ~flush. When valid, dest and ld come from issue_dest and issue_load. Otherwise entry 0 is a bubble.
- flush does not touch entries 1..NSTAGE-1; the branch itself is already in execute.
- stall_cnt increments when stall & ~freeze, and saturates at all-ones.

## Timing
- fwd_hit, fwd_data and stall are combinational from current state and inputs, valid in the same cycle. There is no registered output latency.
- State and stall_cnt update on the rising clk edge.
- Reset values: fwd_hit = 0, fwd_data = 0, stall = 0, stall_cnt = 0.
- A load at stage 0 forces a stall for exactly 1 cycle when LOAD_READY = 1. The next cycle the load sits at stage 1 and is forwarded from stage_data[1].
- With LOAD_READY = L, a dependent instruction stalls L cycles.
- freeze held N cycles: the scoreboard and stall_cnt are unchanged, while outputs keep tracking inputs.
- flush and stall in the same cycle: flush wins, stall = 0, and a bubble is inserted.
- rst asserted mid-operation: all entries invalid on the next edge. Any outstanding hazard is dropped.

## Structure
- Shared package/include proc_pkg holds:
  - default DATA_W and REG_AW;
  - stage index constants STG_EX = 0, STG_MEM = 1, STG_WB = 2;
  - default LOAD_READY.
- One sub-module, fwd_port, instantiated NREAD times:
  - parametrised by NSTAGE, DATA_W, REG_AW, LOAD_READY;
  - purely combinational priority match over the entry vectors;
  - outputs hit, data, hazard.
- The top holds the entry registers, shift/hold/squash logic, stall OR-reduction and counter.

## Test plan
- ALU dependency: issue r3 (non-load), then the next cycle rd_sel[0] = 3 with stage_data[0] = 0x1234 -> fwd_hit[0] = 1, fwd_data[0] = 0x1234, stall = 0.
- Load-use: issue load to r2, next instruction reads r2 on port 1:
  - first cycle: stall = 1, fwd_hit[1] = 0, stall_cnt goes 0 -> 1;
  - following cycle: fwd_hit[1] = 1 with stage_data[1] = 0xBEEF.
- Youngest wins: r5 written at stages 2 and 0 with data 0x0002 and 0x0000 -> fwd_data = 0x0000 from stage 0, then both ports read r5 -> both hit.
- Flush: issue r4 with flush = 1 -> the next cycle no port hits on r4; a concurrent load-use hazard yields stall = 0.
- Freeze: load r1 at stage 0, freeze = 1 for 3 cycles -> stall stays 1 while the dependent reader is present, stall_cnt unchanged, entry still at stage 0 afterward.
- Reset and saturation:
  - rst mid-hazard -> stall = 0 and no hits on the next cycle;
  - with CNT_W = 2, 5 stall cycles -> stall_cnt = 3.
